// File: rtl/run_monitor_if.sv
// Report stream between the run monitor and the host (UART / debug FIFO).
//   rd_valid  report word valid          (master -> slave)
//   rd_ready  host accepts report word   (slave  -> master)
//   rd_data   report word                (master -> slave)
//   rd_last   marks the final word       (master -> slave)
interface run_monitor_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/run_monitor.sv
// Execution monitor placed after the MIPS core. It counts run cycles, retired
// non-NOP instructions and consecutive NOPs. It flags HALT after NOP_LIMIT
// consecutive NOPs, or ABORT when the cycle budget runs out, and then streams
// a 4-word report {tag/status, cycles, instructions, last pc} to the host.
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   i_ir_valid  an instruction issues this cycle
//   i_ir        issued instruction word (0 = NOP)
//   i_pc        PC of the issued instruction
//   o_halted    sticky: program halted normally
//   o_aborted   sticky: cycle budget exhausted
//   o_led       status display
//   rd_if       report stream (valid/ready, data, last)
module run_monitor #(
  parameter int unsigned NOP_LIMIT   = 6,
  parameter int unsigned CYCLE_LIMIT = 10_000_000,
  parameter int unsigned CW          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ir_valid,
  input  logic [31:0]        i_ir,
  input  logic [31:0]        i_pc,
  output logic               o_halted,
  output logic               o_aborted,
  output logic [31:0]        o_led,
  run_monitor_if.master      rd_if
);

  localparam int unsigned NW = $clog2(NOP_LIMIT + 1);

  typedef enum logic [2:0] {StRun, StHalt, StAbort, StDump, StDone} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cyc_cnt;
  logic [CW-1:0]   r_ins_cnt;
  logic [NW-1:0]   r_nop_cnt;
  logic [31:0]     r_last_pc;
  logic [1:0]      r_idx;
  logic            r_halted;
  logic            r_aborted;
  logic            r_rd_valid;
  logic            r_rd_last;
  logic [31:0]     r_rd_data;
  logic [31:0]     r_led;

  logic [CW-1:0]   w_cyc_nxt;
  logic [CW-1:0]   w_ins_nxt;
  logic [NW-1:0]   w_nop_nxt;
  logic [31:0]     w_pc_nxt;
  logic [1:0]      w_word_sel;
  logic [31:0]     w_word;

  // RUN-state counter updates; bubbles leave the NOP run untouched.
  always_comb begin
    w_cyc_nxt = r_cyc_cnt + CW'(1);
    w_nop_nxt = r_nop_cnt;
    w_ins_nxt = r_ins_cnt;
    w_pc_nxt  = r_last_pc;
    if (i_ir_valid) begin
      if (i_ir == 32'h0) begin
        if (r_nop_cnt != NW'(NOP_LIMIT)) w_nop_nxt = r_nop_cnt + NW'(1);
      end else begin
        w_nop_nxt = '0;
        w_ins_nxt = r_ins_cnt + CW'(1);
        w_pc_nxt  = i_pc;
      end
    end
  end

  // Word to load next: the current index on DUMP entry, the following one on a transfer.
  always_comb begin
    w_word_sel = r_rd_valid ? (r_idx + 2'd1) : r_idx;
    w_word     = '0;
    unique case (w_word_sel)
      2'd0: w_word = {16'hC0DE, 14'b0, r_aborted, r_halted};
      2'd1: w_word = 32'(r_cyc_cnt);
      2'd2: w_word = 32'(r_ins_cnt);
      2'd3: w_word = r_last_pc;
      default: w_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StRun;
      r_cyc_cnt  <= '0;
      r_ins_cnt  <= '0;
      r_nop_cnt  <= '0;
      r_last_pc  <= '0;
      r_idx      <= '0;
      r_halted   <= 1'b0;
      r_aborted  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_led      <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          r_cyc_cnt <= w_cyc_nxt;
          r_nop_cnt <= w_nop_nxt;
          r_ins_cnt <= w_ins_nxt;
          r_last_pc <= w_pc_nxt;
          r_led     <= w_pc_nxt;
          // Halt takes priority when both limits are hit on the same cycle.
          if (w_nop_nxt == NW'(NOP_LIMIT)) begin
            r_state <= StHalt;
          end else if (w_cyc_nxt == CW'(CYCLE_LIMIT)) begin
            r_state <= StAbort;
          end
        end
        StHalt: begin
          r_halted <= 1'b1;
          r_led    <= 32'(r_cyc_cnt);
          r_idx    <= '0;
          r_state  <= StDump;
        end
        StAbort: begin
          r_aborted <= 1'b1;
          r_led     <= 32'hDEAD_DEAD;
          r_idx     <= '0;
          r_state   <= StDump;
        end
        StDump: begin
          if (!r_rd_valid) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_word;
            r_rd_last  <= (w_word_sel == 2'd3);
          end else if (rd_if.rd_ready) begin
            if (r_idx == 2'd3) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_state    <= StDone;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_rd_data <= w_word;
              r_rd_last <= (w_word_sel == 2'd3);
            end
          end
        end
        StDone: begin
          r_rd_valid <= 1'b0;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign o_halted       = r_halted;
  assign o_aborted      = r_aborted;
  assign o_led          = r_led;
  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.rd_data  = r_rd_data;
  assign rd_if.rd_last  = r_rd_last;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        rd_ready;

  logic        a_halted, a_aborted, b_halted, b_aborted, c_halted, c_aborted;
  logic [31:0] a_led, b_led, c_led;

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;

  logic        mon_valid, mon_last, mon_halted, mon_aborted;
  logic [31:0] mon_data, mon_led;

  run_monitor_if a_if ();
  run_monitor_if b_if ();
  run_monitor_if c_if ();

  assign a_if.rd_ready = rd_ready;
  assign b_if.rd_ready = rd_ready;
  assign c_if.rd_ready = rd_ready;

  always #5 clk = ~clk;

  run_monitor #(.NOP_LIMIT(6), .CYCLE_LIMIT(20), .CW(32)) u_dut_a (
    .clk(clk), .rst(rst), .i_ir_valid(ir_valid), .i_ir(ir), .i_pc(pc),
    .o_halted(a_halted), .o_aborted(a_aborted), .o_led(a_led), .rd_if(a_if.master)
  );
  run_monitor #(.NOP_LIMIT(6), .CYCLE_LIMIT(9), .CW(32)) u_dut_b (
    .clk(clk), .rst(rst), .i_ir_valid(ir_valid), .i_ir(ir), .i_pc(pc),
    .o_halted(b_halted), .o_aborted(b_aborted), .o_led(b_led), .rd_if(b_if.master)
  );
  run_monitor #(.NOP_LIMIT(1), .CYCLE_LIMIT(20), .CW(32)) u_dut_c (
    .clk(clk), .rst(rst), .i_ir_valid(ir_valid), .i_ir(ir), .i_pc(pc),
    .o_halted(c_halted), .o_aborted(c_aborted), .o_led(c_led), .rd_if(c_if.master)
  );

  // Monitored instance: 0 = A, 2 = C.
  always_comb begin
    mon_valid   = a_if.rd_valid;
    mon_data    = a_if.rd_data;
    mon_last    = a_if.rd_last;
    mon_halted  = a_halted;
    mon_aborted = a_aborted;
    mon_led     = a_led;
    if (sel == 2) begin
      mon_valid   = c_if.rd_valid;
      mon_data    = c_if.rd_data;
      mon_last    = c_if.rd_last;
      mon_halted  = c_halted;
      mon_aborted = c_aborted;
      mon_led     = c_led;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    ir_valid = 1'b0;
    ir       = '0;
    pc       = '0;
    rd_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] p);
    ir_valid = 1'b1;
    ir       = w;
    pc       = p;
    step();
    ir_valid = 1'b0;
    ir       = '0;
  endtask

  // Three instructions at 0x0/0x4/0x8 followed by six NOPs (cycles 1..9).
  task automatic prog_basic();
    issue(32'h2008_0001, 32'h0);
    issue(32'h2009_0002, 32'h4);
    issue(32'h010A_5020, 32'h8);
    for (int i = 0; i < 6; i++) issue(32'h0, 32'h0C + 32'(4 * i));
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 40 && !(mon_halted || mon_aborted); i++) step();
    check_eq({tag, " end reached"}, {31'b0, mon_halted | mon_aborted}, 32'd1);
  endtask

  task automatic collect(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input bit stall);
    logic [31:0] exp [4];
    logic [31:0] held_d;
    logic        held_l;
    bit          stalled;
    int          n;
    exp     = '{e0, e1, e2, e3};
    n       = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      if (stall) rd_ready = (cyc < 5) ? 1'b0 : ((cyc - 5) % 2 == 0);
      else       rd_ready = 1'b1;
      if (mon_valid) begin
        if (stalled) begin
          check_eq($sformatf("%s stall data w%0d", tag, n), mon_data, held_d);
          check_eq($sformatf("%s stall last w%0d", tag, n), {31'b0, mon_last}, {31'b0, held_l});
        end
        if (rd_ready) begin
          check_eq($sformatf("%s data w%0d", tag, n), mon_data, exp[n]);
          check_eq($sformatf("%s last w%0d", tag, n), {31'b0, mon_last}, {31'b0, n == 3});
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = mon_data;
          held_l  = mon_last;
        end
      end
      step();
    end
    check_eq({tag, " transfers"}, 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      rd_ready = i[0];
      check_eq($sformatf("%s idle valid %0d", tag, i), {31'b0, mon_valid}, 32'd0);
      step();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    ir_valid = 1'b0;
    ir       = '0;
    pc       = '0;
    rd_ready = 1'b0;

    // Basic halt run, with the tighter-budget instance hitting both limits together.
    sel = 0;
    do_reset();
    check_eq("rst halted", {31'b0, a_halted}, 32'd0);
    check_eq("rst aborted", {31'b0, a_aborted}, 32'd0);
    check_eq("rst valid", {31'b0, a_if.rd_valid}, 32'd0);
    check_eq("rst data", a_if.rd_data, 32'd0);
    check_eq("rst led", a_led, 32'd0);
    issue(32'h2008_0001, 32'h0);
    issue(32'h2009_0002, 32'h4);
    issue(32'h010A_5020, 32'h8);
    check_eq("t1 led run", a_led, 32'h8);
    for (int i = 0; i < 6; i++) issue(32'h0, 32'h0C + 32'(4 * i));
    check_eq("t1 halted pre", {31'b0, a_halted}, 32'd0);
    rd_ready = 1'b1;
    step();
    check_eq("t1 halted", {31'b0, a_halted}, 32'd1);
    check_eq("t1 aborted", {31'b0, a_aborted}, 32'd0);
    check_eq("t1 led", a_led, 32'd9);
    check_eq("t3 halted", {31'b0, b_halted}, 32'd1);
    check_eq("t3 aborted", {31'b0, b_aborted}, 32'd0);
    collect("t1", 32'hC0DE_0001, 32'd9, 32'd3, 32'h8, 1'b0);
    check_eq("t1 halted hold", {31'b0, a_halted}, 32'd1);

    // NOP runs broken by an instruction, then bubbles: cycle budget ends the run.
    do_reset();
    for (int i = 0; i < 5; i++) issue(32'h0, 32'h1000);
    issue(32'h2008_0005, 32'h40);
    for (int i = 0; i < 5; i++) issue(32'h0, 32'h1000);
    for (int i = 0; i < 5; i++) step();
    check_eq("t2 no halt", {31'b0, a_halted}, 32'd0);
    wait_end("t2");
    check_eq("t2 aborted", {31'b0, a_aborted}, 32'd1);
    check_eq("t2 halted", {31'b0, a_halted}, 32'd0);
    check_eq("t2 led", a_led, 32'hDEAD_DEAD);
    collect("t2", 32'hC0DE_0002, 32'd20, 32'd1, 32'h40, 1'b0);

    // Host back-pressure.
    do_reset();
    prog_basic();
    collect("t4", 32'hC0DE_0001, 32'd9, 32'd3, 32'h8, 1'b1);

    // Reset in the middle of the report, then a fresh run.
    do_reset();
    prog_basic();
    for (int i = 0; i < 10 && !a_if.rd_valid; i++) step();
    check_eq("t5 valid", {31'b0, a_if.rd_valid}, 32'd1);
    check_eq("t5 word0", a_if.rd_data, 32'hC0DE_0001);
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    check_eq("t5 word2", a_if.rd_data, 32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("t5 rst halted", {31'b0, a_halted}, 32'd0);
    check_eq("t5 rst valid", {31'b0, a_if.rd_valid}, 32'd0);
    check_eq("t5 rst last", {31'b0, a_if.rd_last}, 32'd0);
    check_eq("t5 rst data", a_if.rd_data, 32'd0);
    check_eq("t5 rst led", a_led, 32'd0);
    issue(32'h2008_0007, 32'h100);
    issue(32'h2009_0008, 32'h104);
    for (int i = 0; i < 6; i++) issue(32'h0, 32'h108);
    wait_end("t5");
    collect("t5", 32'hC0DE_0001, 32'd8, 32'd2, 32'h104, 1'b0);

    // Single-NOP limit: the very first issued NOP halts.
    sel = 2;
    do_reset();
    issue(32'h0, 32'h200);
    wait_end("t6");
    check_eq("t6 halted", {31'b0, c_halted}, 32'd1);
    check_eq("t6 led", c_led, 32'd1);
    collect("t6", 32'hC0DE_0001, 32'd1, 32'd0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
